ahb_dcd_mux: RTL

- Parametrised AHB-Lite address decoder plus slave-response multiplexer for the bus matrix.
- Decodes HADDR into a one-hot HSEL over NUM_SLV regions using a per-region base table; on overlap, the lowest index wins.
- Registers the selected slave at each accepted address phase and muxes HRDATA/HREADYOUT/HRESP in the data phase.
- Contains a built-in default slave that returns the AHB two-cycle ERROR response for unmapped active transfers.

---
 rtl/ahb_dcd_pkg.sv | 24 ++
 rtl/ahb_default_slave.sv | 59 +++++
 rtl/ahb_dcd_mux.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ahb_dcd_pkg.sv
// Shared constants for the AHB-Lite decoder/response mux: HTRANS codes,
// default-slave state encoding and the default region-tag table.
package ahb_dcd_pkg;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StErr1 = 2'd1,
    StErr2 = 2'd2
  } ds_state_e;

  localparam int unsigned DFLT_NUM_SLV = 8;
  localparam int unsigned DFLT_TAG_W   = 12;

  // Entry 0 sits in the LSBs.
  localparam logic [DFLT_NUM_SLV*DFLT_TAG_W-1:0] DFLT_SLV_BASE = {
    12'hA00, 12'h900, 12'h404, 12'h403, 12'h402, 12'h401, 12'h400, 12'h000
  };

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: answers unmapped NONSEQ/SEQ transfers with the
// two-cycle AHB ERROR response; all outputs are registered.
module ahb_default_slave
  import ahb_dcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hready,
  input  logic [1:0] htrans,
  input  logic       dflt_hit,
  output logic       hreadyout,
  output logic       hresp,
  output logic       err_pulse
);

  ds_state_e state;
  logic      accept_err;

  assign accept_err = hready && dflt_hit && ((htrans == HT_NONSEQ) || (htrans == HT_SEQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      unique case (state)
        StErr1: begin
          state     <= StErr2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
          err_pulse <= 1'b0;
        end
        StIdle, StErr2: begin
          // ERR2 may chain straight into another error without an IDLE cycle.
          if (accept_err) begin
            state     <= StErr1;
            hreadyout <= 1'b0;
            hresp     <= 1'b1;
            err_pulse <= 1'b1;
          end else begin
            state     <= StIdle;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            err_pulse <= 1'b0;
          end
        end
        default: begin
          state     <= StIdle;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
          err_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_dcd_mux.sv
// AHB-Lite address decoder and slave-response multiplexer with default slave.
// Optional unmapped-address capture (ERR_ADDR/ERR_VLD) under AHB_DCD_ERR_CAPTURE_EN.
module ahb_dcd_mux
  import ahb_dcd_pkg::*;
#(
  parameter int unsigned NUM_SLV   = 8,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RGN_SHIFT = 20,
  parameter logic [NUM_SLV*(ADDR_W-RGN_SHIFT)-1:0] SLV_BASE = DFLT_SLV_BASE
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HREADY,
  output logic [NUM_SLV-1:0]        HSEL,
  input  logic [NUM_SLV*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLV-1:0]        HREADYOUT_S,
  input  logic [NUM_SLV-1:0]        HRESP_S,
  output logic [DATA_W-1:0]         HRDATA,
  output logic                      HREADYOUT,
  output logic                      HRESP,
`ifdef AHB_DCD_ERR_CAPTURE_EN
  output logic [ADDR_W-1:0]         ERR_ADDR,
  output logic                      ERR_VLD,
`endif
  output logic                      DCD_ERR
);

  localparam int unsigned TAG_W = ADDR_W - RGN_SHIFT;
  localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  hit_idx;
  logic              dflt_hit;
  logic [IDX_W-1:0]  dp_idx_q;
  logic              dp_dflt_q;
  logic [DATA_W-1:0] slv_rdata;
  logic              slv_ready;
  logic              slv_resp;
  logic              ds_hreadyout;
  logic              ds_hresp;
  logic              unused_addr;

  assign tag         = HADDR[ADDR_W-1:RGN_SHIFT];
  assign unused_addr = ^HADDR[RGN_SHIFT-1:0];

  // First matching entry wins, so overlapping regions resolve to the lowest index.
  always_comb begin
    HSEL     = '0;
    dflt_hit = 1'b1;
    hit_idx  = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (dflt_hit && (tag == SLV_BASE[i*TAG_W +: TAG_W])) begin
        dflt_hit = 1'b0;
        hit_idx  = IDX_W'(i);
        HSEL[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_dflt_q <= 1'b1;
      dp_idx_q  <= '0;
    end else if (HREADY) begin
      dp_dflt_q <= dflt_hit;
      dp_idx_q  <= hit_idx;
    end
  end

  always_comb begin
    slv_rdata = '0;
    slv_ready = 1'b1;
    slv_resp  = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (dp_idx_q == IDX_W'(i)) begin
        slv_rdata = HRDATA_S[i*DATA_W +: DATA_W];
        slv_ready = HREADYOUT_S[i];
        slv_resp  = HRESP_S[i];
      end
    end
  end

  assign HRDATA    = dp_dflt_q ? '0 : slv_rdata;
  assign HREADYOUT = dp_dflt_q ? ds_hreadyout : slv_ready;
  assign HRESP     = dp_dflt_q ? ds_hresp : slv_resp;

  ahb_default_slave u_default_slave (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .hready    (HREADY),
    .htrans    (HTRANS),
    .dflt_hit  (dflt_hit),
    .hreadyout (ds_hreadyout),
    .hresp     (ds_hresp),
    .err_pulse (DCD_ERR)
  );

`ifdef AHB_DCD_ERR_CAPTURE_EN
  logic err_start;

  // The default slave holds hreadyout low only in ERR1, the one state that ignores new transfers.
  assign err_start = HREADY && dflt_hit && ds_hreadyout &&
                     ((HTRANS == HT_NONSEQ) || (HTRANS == HT_SEQ));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ERR_ADDR <= '0;
      ERR_VLD  <= 1'b0;
    end else if (err_start) begin
      ERR_ADDR <= HADDR;
      ERR_VLD  <= 1'b1;
    end
  end
`else
  // Capture disabled: no error-address state.
`endif

endmodule
